// File: rtl/branch_ctrl.sv
// Branch/launch controller for the fetch unit: sequences program start,
// decodes BZ/JMP/HALT at the current PC and issues a one-cycle redirect with flush.
module branch_ctrl (
    input  logic        f_clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [7:0]  prog_addr,
    input  logic [7:0]  pc_i,
    input  logic [8:0]  instr_i,
    input  logic        zero_i,
    output logic        start,
    output logic [7:0]  start_addr,
    output logic        branch,
    output logic [7:0]  target,
    output logic        taken,
    output logic        flush,
    output logic        halted,
    output logic        busy,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic        redir_q, redir_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  start_addr_q, start_addr_d;
    logic [15:0] icount_q, icount_d;

    logic       go_accept;
    logic       decode_en;
    logic       is_bz, is_jmp, is_halt;
    logic       br_taken;
    logic [7:0] br_target;

    // The instruction sitting in the redirect shadow is never decoded.
    assign go_accept = go && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign decode_en = (state_q == S_RUN) && !redir_q;

    assign is_halt   = (instr_i[8:6] == 3'b111) && (instr_i[5:0] == 6'h3F);
    assign is_jmp    = (instr_i[8:6] == 3'b111) && !is_halt;
    assign is_bz     = (instr_i[8:6] == 3'b110);
    assign br_taken  = is_jmp || (is_bz && zero_i);
    assign br_target = pc_i + {{2{instr_i[5]}}, instr_i[5:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge f_clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            redir_q      <= 1'b0;
            target_q     <= 8'h00;
            start_addr_q <= 8'h00;
            icount_q     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            redir_q      <= redir_d;
            target_q     <= target_d;
            start_addr_q <= start_addr_d;
            icount_q     <= icount_d;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        redir_d      = 1'b0;
        target_d     = target_q;
        start_addr_d = start_addr_q;
        icount_d     = icount_q;

        case (state_q)
            S_IDLE: if (go_accept) state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN:  if (decode_en && is_halt) state_d = S_HALT;
            S_HALT: if (go_accept) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase

        if (go_accept) begin
            start_addr_d = prog_addr;
            icount_d     = 16'h0000;
        end

        if (decode_en) begin
            if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
            if (is_halt) begin
                target_d = pc_i;
            end else if (br_taken) begin
                redir_d  = 1'b1;
                target_d = br_target;
            end
        end
    end

    // Halt keeps taken asserted so fetch stays frozen on the halt PC.
    always_comb begin
        start      = (state_q == S_LOAD);
        busy       = (state_q == S_LOAD) || (state_q == S_RUN);
        halted     = (state_q == S_HALT);
        taken      = redir_q || (state_q == S_HALT);
        branch     = redir_q;
        flush      = redir_q;
        target     = target_q;
        start_addr = start_addr_q;
        icount     = icount_q;
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios with literal
// expectations, then random stimulus checked every cycle against a behavioural model.
module tb_branch_ctrl;

    logic        f_clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic [7:0]  prog_addr;
    logic [7:0]  pc_i;
    logic [8:0]  instr_i;
    logic        zero_i;
    logic        start;
    logic [7:0]  start_addr;
    logic        branch;
    logic [7:0]  target;
    logic        taken;
    logic        flush;
    logic        halted;
    logic        busy;
    logic [15:0] icount;

    int n_checks = 0;
    int n_fail   = 0;

    branch_ctrl dut (
        .f_clk      (f_clk),
        .rst_n      (rst_n),
        .go         (go),
        .prog_addr  (prog_addr),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .zero_i     (zero_i),
        .start      (start),
        .start_addr (start_addr),
        .branch     (branch),
        .target     (target),
        .taken      (taken),
        .flush      (flush),
        .halted     (halted),
        .busy       (busy),
        .icount     (icount)
    );

    always #5 f_clk = ~f_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks launch, running, halted and shadow-slot status.
    bit        m_loading, m_running, m_halted, m_shadow;
    bit [7:0]  m_start_addr, m_target;
    int        m_icount;
    bit        chk_en = 1'b0;

    always @(posedge f_clk) begin : model
        int       off;
        bit [2:0] op;
        if (!rst_n) begin
            m_loading    <= 1'b0;
            m_running    <= 1'b0;
            m_halted     <= 1'b0;
            m_shadow     <= 1'b0;
            m_start_addr <= 8'h00;
            m_target     <= 8'h00;
            m_icount     <= 0;
        end else if (!m_loading && !m_running && go) begin
            m_loading    <= 1'b1;
            m_halted     <= 1'b0;
            m_start_addr <= prog_addr;
            m_icount     <= 0;
        end else if (m_loading) begin
            m_loading <= 1'b0;
            m_running <= 1'b1;
        end else if (m_running) begin
            if (m_shadow) begin
                m_shadow <= 1'b0;
            end else begin
                m_icount <= (m_icount >= 65535) ? 65535 : m_icount + 1;
                op  = instr_i[8:6];
                off = instr_i[5] ? int'(instr_i[5:0]) - 64 : int'(instr_i[5:0]);
                if (op == 3'b111 && instr_i[5:0] == 6'h3F) begin
                    m_running <= 1'b0;
                    m_halted  <= 1'b1;
                    m_target  <= pc_i;
                end else if (op == 3'b111 || (op == 3'b110 && zero_i)) begin
                    m_shadow <= 1'b1;
                    m_target <= 8'((int'(pc_i) + off + 256) % 256);
                end
            end
        end
        chk_en <= 1'b1;
    end

    always @(negedge f_clk) begin
        if (chk_en) begin
            check("m_start",      start,      m_loading);
            check("m_busy",       busy,       m_loading | m_running);
            check("m_halted",     halted,     m_halted);
            check("m_taken",      taken,      m_shadow | m_halted);
            check("m_branch",     branch,     m_shadow);
            check("m_flush",      flush,      m_shadow);
            check("m_target",     target,     m_target);
            check("m_start_addr", start_addr, m_start_addr);
            check("m_icount",     icount,     m_icount);
        end
    end

    task automatic tick();
        @(posedge f_clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; prog_addr = 8'h00;
        pc_i = 8'h00; instr_i = 9'h000; zero_i = 1'b0;

        // Reset and launch
        repeat (3) tick();
        @(negedge f_clk);
        check("rst_busy",   busy,   1'b0);
        check("rst_taken",  taken,  1'b0);
        check("rst_icount", icount, 16'h0);
        rst_n = 1'b1; go = 1'b1; prog_addr = 8'h10;
        tick();
        go = 1'b0;
        @(negedge f_clk);
        check("launch_start", start,      1'b1);
        check("launch_addr",  start_addr, 8'h10);
        check("launch_busy",  busy,       1'b1);
        tick();

        // Taken BZ -4 at 0x20
        pc_i = 8'h20; instr_i = 9'b110_111100; zero_i = 1'b1;
        tick();
        instr_i = 9'h000;
        @(negedge f_clk);
        check("bz_taken",  taken,  1'b1);
        check("bz_branch", branch, 1'b1);
        check("bz_target", target, 8'h1C);
        check("bz_flush",  flush,  1'b1);
        check("bz_icount", icount, 16'd1);
        tick();
        @(negedge f_clk);
        check("bz_taken_clr", taken,  1'b0);
        check("bz_flush_clr", flush,  1'b0);
        check("bz_icount2",   icount, 16'd1);

        // Not-taken BZ
        instr_i = 9'b110_000011; zero_i = 1'b0;
        tick();
        @(negedge f_clk);
        check("nt_taken",  taken,  1'b0);
        check("nt_flush",  flush,  1'b0);
        check("nt_icount", icount, 16'd2);

        // JMP +5 at 0xFE wraps, HALT in its shadow is ignored
        pc_i = 8'hFE; instr_i = 9'b111_000101;
        tick();
        instr_i = 9'h1FF;
        @(negedge f_clk);
        check("jmp_target", target, 8'h03);
        check("jmp_taken",  taken,  1'b1);
        check("jmp_icount", icount, 16'd3);
        tick();
        instr_i = 9'h000;
        @(negedge f_clk);
        check("shadow_halted", halted, 1'b0);
        check("shadow_busy",   busy,   1'b1);
        check("shadow_icount", icount, 16'd3);
        check("shadow_taken",  taken,  1'b0);

        // HALT at 0x40 holds for 10 cycles, then relaunch at 0x80
        pc_i = 8'h40; instr_i = 9'h1FF;
        tick();
        instr_i = 9'h000;
        for (int i = 0; i < 10; i++) begin
            @(negedge f_clk);
            check("halt_halted", halted, 1'b1);
            check("halt_taken",  taken,  1'b1);
            check("halt_target", target, 8'h40);
            check("halt_branch", branch, 1'b0);
            check("halt_icount", icount, 16'd4);
            tick();
        end
        go = 1'b1; prog_addr = 8'h80;
        tick();
        go = 1'b0;
        @(negedge f_clk);
        check("relaunch_start",  start,      1'b1);
        check("relaunch_addr",   start_addr, 8'h80);
        check("relaunch_icount", icount,     16'd0);
        check("relaunch_halted", halted,     1'b0);
        check("relaunch_taken",  taken,      1'b0);
        tick();

        // Reset on the cycle a taken JMP is decoded
        pc_i = 8'h90; instr_i = 9'b111_000010; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; instr_i = 9'h000;
        @(negedge f_clk);
        check("mrst_taken",  taken,  1'b0);
        check("mrst_busy",   busy,   1'b0);
        check("mrst_target", target, 8'h00);
        check("mrst_addr",   start_addr, 8'h00);
        tick();
        @(negedge f_clk);
        check("mrst_taken2", taken, 1'b0);
        check("mrst_busy2",  busy,  1'b0);

        // Random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            rst_n     = ($urandom_range(0, 299) != 0);
            go        = ($urandom_range(0, 15) == 0);
            prog_addr = 8'($urandom);
            pc_i      = 8'($urandom);
            zero_i    = 1'($urandom);
            r = $urandom_range(0, 11);
            if (r < 3)       instr_i = {3'b110, 6'($urandom)};
            else if (r < 5)  instr_i = {3'b111, 6'($urandom)};
            else if (r == 5) instr_i = 9'h1FF;
            else             instr_i = {3'($urandom_range(0, 5)), 6'($urandom)};
            tick();
        end

        @(negedge f_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Control-side companion to the fetch unit: drives its `start`, `start_addr`, `branch`, `target` and `taken` inputs. Sequences program launch and decodes branch/halt instructions returned from instruction memory for the current `pc`. Registers the redirect for one cycle and flushes the shadow instruction. Sits between instruction memory, the ALU zero flag, and the fetch unit, all on the fetch clock.

## Interface
- No parameters.
- `f_clk` in 1 — fetch clock; all state updates on its rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `go` in 1 — launch request; accepted only in IDLE or HALT.
- `prog_addr` in 8 — program entry address, sampled when `go` is accepted.
- `pc_i` in 8 — current fetch PC (fetch unit `pc_o`).
- `instr_i` in 9 — instruction word at `pc_i`.
- `zero_i` in 1 — ALU zero flag, sampled with `instr_i`.
- `start` out 1 — one-cycle launch pulse to fetch unit.
- `start_addr` out 8 — launch address.
- `branch` out 1 — current redirect comes from a branch instruction.
- `target` out 8 — redirect address.
- `taken` out 1 — redirect fetch to `target`.
- `flush` out 1 — instruction presently at `pc_i` is a shadow; downstream must squash it.
- `halted` out 1 — program halted.
- `busy` out 1 — state is LOAD or RUN.
- `icount` out 16 — retired (non-flushed) instructions since launch.

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset: IDLE.
- Decode, RUN only, non-flush cycles: `instr_i[8:6]` = 3'b110 → BZ; taken iff `zero_i`=1. 3'b111 with `instr_i[5:0]`=6'h3F → HALT. 3'b111 otherwise → JMP, always taken. Every other opcode is non-control.
- Branch target = `pc_i` + sign-extended `instr_i[5:0]` (−32..+31), truncated to 8 bits; wraps modulo 256 (0xFE + 5 = 0x03; 0x02 − 4 = 0xFE).
- IDLE: `go`=1 → LOAD; latch `prog_addr` into `start_addr`.
- LOAD: `start`=1 for exactly one cycle → RUN.
- RUN:
  - Taken BZ/JMP → next cycle `taken`=1, `branch`=1, `target` set, `flush`=1. All return to 0 the cycle after.
  - Not-taken BZ → no redirect; counts as retired.
  - HALT → HALT state; `target`=`pc_i` of the halt instruction, `taken`=1 held to freeze fetch; `branch`=0.
- HALT: `halted`=1, `taken`=1, `target` held. `go`=1 → LOAD with new `prog_addr`; clears `halted`/`taken`; `icount` reset to 0.
- Flush cycle: `instr_i` ignored, including branch or halt in the shadow; not counted.
- `icount` increments once per decoded non-flush RUN cycle, HALT included. Saturates at 0xFFFF.
- `go` in LOAD or RUN: ignored.
- `rst_n`=0 in any state: next edge → IDLE. All outputs 0, `icount`=0, in-flight redirect discarded.

## Timing
- All outputs are registered; no combinational input→output path.
- Reset values: all outputs 0; `start_addr`=0.
- `go` accepted at edge E → `start`=1 during cycle E+1 → RUN from E+2.
- Branch decoded in cycle N → `taken`/`target` valid in N+1, the same cycle `flush`=1. Fetch lands at `target` in N+2.
- Back-to-back taken branches: second branch sits in a flush slot and is ignored. Minimum spacing is 2 cycles.
- Halt decoded in N → `halted`=1 from N+1.
- `busy`=1 exactly while in LOAD or RUN.

## Test plan
- Reset/launch: hold `rst_n`=0 three cycles, then `go`=1 with `prog_addr`=0x10. Expect all outputs 0 during reset; `start`=1 and `start_addr`=0x10 one cycle later; `busy`=1.
- Taken BZ: `pc_i`=0x20, `instr_i`=9'b110_111100 (−4), `zero_i`=1. Next cycle expect `taken`=1, `branch`=1, `target`=0x1C, `flush`=1; the cycle after, all 0. `icount` +1 only.
- Not-taken BZ with `zero_i`=0 → no `taken`, no flush. Then JMP +5 at `pc_i`=0xFE → `target`=0x03 (wrap).
- Shadow suppression: JMP, then a HALT in its flush slot. HALT is ignored and not counted; state stays RUN.
- Halt/relaunch: HALT at 0x40 → `halted`=1, `taken`=1, `target`=0x40 held 10 cycles. `go`=1 with 0x80 → `start` pulse, `icount`=0, `halted`=0.
- Mid-run reset: `rst_n`=0 the cycle a taken branch is decoded. Expect no `taken` pulse afterwards; IDLE with all outputs 0.
